obi_rr_bridge: RTL
==================

# obi_rr_bridge

Parametrised OBI bridge between NCH processor-side requestor channels (instruction fetch, load/store, debug, DMA) and a single OBI memory port. It arbitrates address-phase requests round-robin, keeps an in-order FIFO of per-transaction channel IDs so several transactions can be outstanding, and routes each response to the channel that issued it. It generalises the fixed two-port fetch/load-store interface to any channel count, any address and data width, and pipelined memories.

## Interface
- NCH, 2, number of requestor channels (≥2)
- AW, 32, address width
- DW, 32, data width
- MAX_OUTST, 4, maximum outstanding transactions; power of two, ≥1
- clk  in  1  clock, rising edge
- rst  in  1  reset, asynchronous, active-low
- ch_req  in  NCH  per-channel request; held high with stable fields until ch_gnt
- ch_addr  in  NCH*AW  per-channel address; channel i occupies bits [i*AW +: AW]
- ch_web  in  NCH  per-channel write enable, active-low
- ch_wdata  in  NCH*DW  per-channel write data
- ch_gnt  out  NCH  one-hot grant, address phase accepted
- ch_rvalid  out  NCH  one-hot response valid
- ch_rdata  out  DW  shared response data, meaningful where ch_rvalid is set
- mem_req  out  1  request to memory
- mem_addr  out  AW  address of the selected channel
- mem_web  out  1  write enable of the selected channel, active-low
- mem_wdata  out  DW  write data of the selected channel
- mem_gnt  in  1  memory accepts the address phase
- mem_rvalid  in  1  memory response valid, always in order
- mem_rdata  in  DW  memory response data
- outst_cnt  out  $clog2(MAX_OUTST+1)  outstanding transaction count
- err_rsp  out  1  sticky flag: mem_rvalid arrived while no transaction was outstanding

## Operation
- Arbitration: round-robin. prio_ptr names the highest-priority channel. The winner is the first requesting channel at or after prio_ptr, searched modulo NCH.
- Lock: if mem_req is high and mem_gnt is low, the current winner is latched (lock_vld, lock_id). The selection holds until a grant, even if a higher-priority channel raises ch_req. This keeps mem_addr, mem_web and mem_wdata stable as OBI requires.
- can_issue = (outst_cnt < MAX_OUTST) || mem_rvalid.
- mem_req = can_issue && (lock_vld || |ch_req).
- Accept = mem_req && mem_gnt. On accept:
  - ch_gnt[winner] = 1 in the same cycle (combinational).
  - winner is pushed into the ID FIFO.
  - prio_ptr <= (winner+1) mod NCH.
  - lock is cleared.
- Response: when mem_rvalid is high and the FIFO is not empty:
  - ch_rvalid[fifo_head] = 1 and ch_rdata = mem_rdata, both combinational.
  - the FIFO pops.
- Writes also receive exactly one mem_rvalid; it is routed the same way as a read response.
- A simultaneous push and pop leaves outst_cnt unchanged. Push when full is allowed only together with a pop.
- mem_rvalid with an empty FIFO: the response is dropped, no ch_rvalid is asserted, and err_rsp is set and stays set until reset.
- A channel dropping ch_req while locked is a protocol violation. The lock remains, and mem_req stays high until granted.
- The FIFO is a circular buffer with wrapping read and write pointers of width $clog2(MAX_OUTST). outst_cnt tracks occupancy.

## Timing
- Reset (rst low, asynchronous):
  - prio_ptr=0, lock_vld=0, FIFO empty, outst_cnt=0, err_rsp=0.
  - ch_gnt=0, ch_rvalid=0, mem_req=0.
  - mem_addr, mem_wdata and ch_rdata follow their combinational sources and are 0 while all inputs are 0. mem_web=1 while no request is selected.
- Reset during outstanding transactions discards them. Later stray mem_rvalid pulses set err_rsp.
- Latency: zero added cycles. ch_req→mem_req, mem_gnt→ch_gnt and mem_rvalid→ch_rvalid are all combinational paths.
- Throughput: one accept per cycle with continuous mem_gnt. Back-to-back issue continues up to MAX_OUTST in flight.
- All state (prio_ptr, lock, FIFO, outst_cnt, err_rsp) updates on the rising edge of clk.

## Test plan
- Single channel read:
  - Stimulus: NCH=2; ch_req[0]=1, addr 0x100, mem_gnt=1. Two cycles later mem_rvalid=1, rdata 0xDEADBEEF.
  - Required: ch_gnt[0] is high in cycle 0. ch_rvalid[0]=1 with ch_rdata=0xDEADBEEF in cycle 2. outst_cnt goes 0→1→0.
- Round-robin fairness:
  - Stimulus: NCH=4; all ch_req high; mem_gnt=1; mem_rvalid=1 every cycle from cycle 1.
  - Required: grant order 0,1,2,3,0. Responses arrive as ch_rvalid[0],[1],[2],[3] in that order.
- Lock under stall:
  - Stimulus: ch_req[1] high, mem_gnt=0 for 3 cycles; ch_req[0] rises in cycle 1.
  - Required: mem_addr stays at ch1's address. ch_gnt[1] is asserted first, and ch0 is granted next.
- Full FIFO:
  - Stimulus: MAX_OUTST=2; three requests; mem_gnt=1; no rvalid.
  - Required: after two accepts, mem_req=0 and outst_cnt=2.
  - Then: mem_rvalid=1 in the next cycle.
  - Required: a same-cycle accept occurs and outst_cnt stays 2.
- Stray response:
  - Stimulus: mem_rvalid=1 with an empty FIFO.
  - Required: ch_rvalid=0 and err_rsp=1 from the next cycle. err_rsp persists until rst is asserted.
- Reset mid-transaction:
  - Stimulus: 3 transactions outstanding; rst pulsed low mid-cycle.
  - Required: outst_cnt=0 and mem_req=0 immediately. prio_ptr=0, shown by channel 0 winning the next contention.

Source files
------------

// File: rtl/obi_rr_bridge.sv
`default_nettype none
// ============================================================================
//  Module      : obi_rr_bridge
//  Description : Round-robin OBI bridge from NCH requestor channels to one
//                memory port. It keeps an in-order ID FIFO so that responses
//                are routed back to the channel that issued each transaction.
//  Revision    : 1.0  initial release
// ============================================================================
module obi_rr_bridge #(
    parameter int NCH       = 2,
    parameter int AW        = 32,
    parameter int DW        = 32,
    parameter int MAX_OUTST = 4
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [NCH-1:0]                 ch_req,
    input  logic [NCH*AW-1:0]              ch_addr,
    input  logic [NCH-1:0]                 ch_web,
    input  logic [NCH*DW-1:0]              ch_wdata,
    output logic [NCH-1:0]                 ch_gnt,
    output logic [NCH-1:0]                 ch_rvalid,
    output logic [DW-1:0]                  ch_rdata,
    output logic                           mem_req,
    output logic [AW-1:0]                  mem_addr,
    output logic                           mem_web,
    output logic [DW-1:0]                  mem_wdata,
    input  logic                           mem_gnt,
    input  logic                           mem_rvalid,
    input  logic [DW-1:0]                  mem_rdata,
    output logic [$clog2(MAX_OUTST+1)-1:0] outst_cnt,
    output logic                           err_rsp
);

    localparam int C_PW = (NCH > 1) ? $clog2(NCH) : 1;
    localparam int C_FW = (MAX_OUTST > 1) ? $clog2(MAX_OUTST) : 1;
    localparam int C_CW = $clog2(MAX_OUTST + 1);

    localparam logic [C_PW-1:0] C_LAST_CH = C_PW'(NCH - 1);
    localparam logic [C_CW-1:0] C_MAX_CNT = C_CW'(MAX_OUTST);

    logic [C_PW-1:0] r_prio_ptr;
    logic            r_lock_vld;
    logic [C_PW-1:0] r_lock_id;
    logic [C_CW-1:0] r_cnt;
    logic            r_err;

    logic [C_PW-1:0] w_hi_id;
    logic            w_hi_vld;
    logic [C_PW-1:0] w_lo_id;
    logic [C_PW-1:0] w_arb_id;
    logic [C_PW-1:0] w_sel_id;
    logic            w_sel_web;
    logic            w_any;
    logic            w_can_issue;
    logic            w_accept;
    logic            w_pop;
    logic            w_stray;
    logic [C_PW-1:0] w_head;

    // Scanning downwards leaves the lowest-numbered requester in each half:
    // "hi" covers channels at or above prio_ptr, "lo" the whole vector for the wrap.
    always_comb begin
        w_hi_id  = '0;
        w_hi_vld = 1'b0;
        w_lo_id  = '0;
        for (int i = NCH - 1; i >= 0; i--) begin
            if (ch_req[i]) begin
                w_lo_id = C_PW'(i);
                if (C_PW'(i) >= r_prio_ptr) begin
                    w_hi_id  = C_PW'(i);
                    w_hi_vld = 1'b1;
                end
            end
        end
        w_arb_id = w_hi_vld ? w_hi_id : w_lo_id;
    end

    assign w_sel_id    = r_lock_vld ? r_lock_id : w_arb_id;
    assign w_any       = rst && (r_lock_vld || (|ch_req));
    assign w_can_issue = (r_cnt < C_MAX_CNT) || mem_rvalid;
    assign mem_req     = w_can_issue && w_any;
    assign w_accept    = mem_req && mem_gnt;
    assign w_pop       = rst && mem_rvalid && (r_cnt != '0);
    assign w_stray     = mem_rvalid && (r_cnt == '0);

    always_comb begin
        mem_addr  = '0;
        mem_wdata = '0;
        w_sel_web = 1'b1;
        for (int i = 0; i < NCH; i++) begin
            if (w_sel_id == C_PW'(i)) begin
                mem_addr  = ch_addr[i*AW +: AW];
                mem_wdata = ch_wdata[i*DW +: DW];
                w_sel_web = ch_web[i];
            end
        end
    end

    assign mem_web = w_any ? w_sel_web : 1'b1;

    always_comb begin
        ch_gnt    = '0;
        ch_rvalid = '0;
        for (int i = 0; i < NCH; i++) begin
            ch_gnt[i]    = w_accept && (w_sel_id == C_PW'(i));
            ch_rvalid[i] = w_pop && (w_head == C_PW'(i));
        end
    end

    assign ch_rdata  = mem_rdata;
    assign outst_cnt = r_cnt;
    assign err_rsp   = r_err;

    // Arbitration, lock and occupancy state
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_prio_ptr <= '0;
            r_lock_vld <= 1'b0;
            r_lock_id  <= '0;
            r_cnt      <= '0;
            r_err      <= 1'b0;
        end else begin
            if (w_accept) begin
                r_prio_ptr <= (w_sel_id == C_LAST_CH) ? '0 : w_sel_id + 1'b1;
                r_lock_vld <= 1'b0;
            end else if (mem_req) begin
                r_lock_vld <= 1'b1;
                r_lock_id  <= w_sel_id;
            end
            case ({w_accept, w_pop})
                2'b10:   r_cnt <= r_cnt + 1'b1;
                2'b01:   r_cnt <= r_cnt - 1'b1;
                default: r_cnt <= r_cnt;
            endcase
            if (w_stray) begin
                r_err <= 1'b1;
            end
        end
    end

    generate
        if (MAX_OUTST > 1) begin : g_fifo_multi
            localparam logic [C_FW-1:0] C_LAST_SLOT = C_FW'(MAX_OUTST - 1);

            logic [C_PW-1:0] r_fifo [MAX_OUTST];
            logic [C_FW-1:0] r_wr_ptr;
            logic [C_FW-1:0] r_rd_ptr;

            always_ff @(posedge clk or negedge rst) begin
                if (!rst) begin
                    r_wr_ptr <= '0;
                    r_rd_ptr <= '0;
                end else begin
                    if (w_accept) begin
                        r_wr_ptr <= (r_wr_ptr == C_LAST_SLOT) ? '0 : r_wr_ptr + 1'b1;
                    end
                    if (w_pop) begin
                        r_rd_ptr <= (r_rd_ptr == C_LAST_SLOT) ? '0 : r_rd_ptr + 1'b1;
                    end
                end
            end

            // Payload needs no reset: occupancy alone decides what is valid
            always_ff @(posedge clk) begin
                if (w_accept) begin
                    r_fifo[r_wr_ptr] <= w_sel_id;
                end
            end

            assign w_head = r_fifo[r_rd_ptr];
        end else begin : g_fifo_single
            logic [C_PW-1:0] r_slot;

            always_ff @(posedge clk) begin
                if (w_accept) begin
                    r_slot <= w_sel_id;
                end
            end

            assign w_head = r_slot;
        end
    endgenerate

endmodule
`default_nettype wire
